// File: rtl/cpu_pkg.sv
// Shared opcode map, sequencer state and decode-record types for the 8-bit accumulator CPU.
// Opcode values are also used by the ALU, so they must stay in step with it.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_NOR  = 4'h3;
    localparam logic [3:0] OP_MOVR = 4'h4;
    localparam logic [3:0] OP_MOVA = 4'h5;
    localparam logic [3:0] OP_JZ   = 4'h6;
    localparam logic [3:0] OP_JC   = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hB;
    localparam logic [3:0] OP_SHR  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ACC_SRC_ALU = 2'd0;
    localparam logic [1:0] ACC_SRC_RF  = 2'd1;
    localparam logic [1:0] ACC_SRC_IMM = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_FETCH2,
        ST_EXEC,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        BR_NONE,
        BR_JZ,
        BR_JC,
        BR_JMP
    } br_t;

    typedef struct packed {
        logic       alu_op;
        logic       two_byte;
        logic       illegal;
        logic       halt;
        logic       nop;
        logic       acc_we;
        logic       rf_we;
        logic       upd_c;
        logic [1:0] acc_src;
        br_t        br;
    } dec_t;

    function automatic logic is_two_byte(input logic [3:0] op);
        return (op == OP_JZ) || (op == OP_JC) || (op == OP_JMP) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Sequencer-facing bundle: fetch port, ALU opcode/flags, accumulator and register-file strobes, status.
// master = the sequencer, slave = memory/ALU/storage side.
interface cpu_seq_ctrl_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [7:0]      imem_rdata;
    logic            imem_ack;
    logic [3:0]      alu_sel;
    logic            alu_z;
    logic            alu_c;
    logic [3:0]      rf_addr;
    logic            rf_we;
    logic            acc_we;
    logic [1:0]      acc_src;
    logic [7:0]      imm;
    logic            flag_z;
    logic            flag_c;
    logic            halted;
    logic            illegal;

    modport master (
        output imem_req, imem_addr, alu_sel, rf_addr, rf_we, acc_we, acc_src,
               imm, flag_z, flag_c, halted, illegal,
        input  imem_rdata, imem_ack, alu_z, alu_c
    );

    modport slave (
        input  imem_req, imem_addr, alu_sel, rf_addr, rf_we, acc_we, acc_src,
               imm, flag_z, flag_c, halted, illegal,
        output imem_rdata, imem_ack, alu_z, alu_c
    );
endinterface

// File: rtl/cpu_inst_decode.sv
// Combinational opcode classifier: ALU/two-byte/illegal/halt flags, strobe class, acc source, branch type.
// Zero latency, no handshake; undefined opcodes are flagged illegal and otherwise behave as NOP.
module cpu_inst_decode
    import cpu_pkg::*;
(
    input  logic [3:0] i_opcode,
    output dec_t       o_dec
);
    always_comb begin
        o_dec          = '0;
        o_dec.two_byte = is_two_byte(i_opcode);
        case (i_opcode)
            OP_NOP: o_dec.nop = 1'b1;
            OP_ADD, OP_SUB, OP_SHL, OP_SHR: begin
                o_dec.alu_op  = 1'b1;
                o_dec.acc_we  = 1'b1;
                o_dec.upd_c   = 1'b1;
                o_dec.acc_src = ACC_SRC_ALU;
            end
            // NOR has no meaningful carry, so it leaves the C flag alone
            OP_NOR: begin
                o_dec.alu_op  = 1'b1;
                o_dec.acc_we  = 1'b1;
                o_dec.acc_src = ACC_SRC_ALU;
            end
            OP_MOVR: begin
                o_dec.acc_we  = 1'b1;
                o_dec.acc_src = ACC_SRC_RF;
            end
            OP_MOVA: o_dec.rf_we = 1'b1;
            OP_JZ:   o_dec.br    = BR_JZ;
            OP_JC:   o_dec.br    = BR_JC;
            OP_JMP:  o_dec.br    = BR_JMP;
            OP_LDI: begin
                o_dec.acc_we  = 1'b1;
                o_dec.acc_src = ACC_SRC_IMM;
            end
            OP_HALT: o_dec.halt    = 1'b1;
            default: o_dec.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/cpu_seq_ctrl.sv
// Fetch/decode/execute sequencer owning PC, IR, immediate and Z/C flags; 2-4 cycles per instruction at zero wait.
// Fetches stall indefinitely on imem_ack; synchronous reset aborts any outstanding fetch and masks all strobes.
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    cpu_seq_ctrl_if.master bus
);
    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_ir;
    logic [7:0]      r_imm;
    logic            r_flag_z;
    logic            r_flag_c;
    dec_t            w_dec;
    logic            w_take;

    cpu_inst_decode u_dec (
        .i_opcode (r_ir[7:4]),
        .o_dec    (w_dec)
    );

    // Branches test the latched flags only, never the live ALU outputs
    always_comb begin
        w_take = 1'b0;
        case (w_dec.br)
            BR_JZ:   w_take = r_flag_z;
            BR_JC:   w_take = r_flag_c;
            BR_JMP:  w_take = 1'b1;
            default: w_take = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  if (bus.imem_ack) w_next = ST_DECODE;
            ST_DECODE: begin
                if (w_dec.two_byte)                w_next = ST_FETCH2;
                else if (w_dec.halt)               w_next = ST_HALT;
                else if (w_dec.illegal || w_dec.nop) w_next = ST_FETCH;
                else                               w_next = ST_EXEC;
            end
            ST_FETCH2: if (bus.imem_ack) w_next = ST_EXEC;
            ST_EXEC:   w_next = ST_FETCH;
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_imm    <= '0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: if (bus.imem_ack) begin
                    r_ir <= bus.imem_rdata;
                    r_pc <= r_pc + PC_W'(1);
                end
                ST_FETCH2: if (bus.imem_ack) begin
                    r_imm <= bus.imem_rdata;
                    r_pc  <= r_pc + PC_W'(1);
                end
                ST_EXEC: begin
                    if (w_dec.alu_op) begin
                        r_flag_z <= bus.alu_z;
                        if (w_dec.upd_c) r_flag_c <= bus.alu_c;
                    end
                    if (w_take) r_pc <= PC_W'(r_imm);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.imem_req = 1'b0;
        bus.alu_sel  = OP_NOP;
        bus.acc_we   = 1'b0;
        bus.rf_we    = 1'b0;
        bus.acc_src  = ACC_SRC_ALU;
        bus.illegal  = 1'b0;
        bus.halted   = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_FETCH, ST_FETCH2: bus.imem_req = 1'b1;
                ST_DECODE:           bus.illegal  = w_dec.illegal;
                ST_EXEC: begin
                    bus.acc_we  = w_dec.acc_we;
                    bus.rf_we   = w_dec.rf_we;
                    bus.acc_src = w_dec.acc_src;
                    if (w_dec.alu_op) bus.alu_sel = r_ir[7:4];
                end
                ST_HALT: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.imem_addr = r_pc;
    assign bus.rf_addr   = r_ir[3:0];
    assign bus.imm       = r_imm;
    assign bus.flag_z    = r_flag_z;
    assign bus.flag_c    = r_flag_c;
endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU. Owns PC, instruction register and the Z/C flag register. Fetches instruction bytes over a req/ack memory port and drives the ALU opcode. Also drives the accumulator and register-file write strobes and takes branches on latched flags. The ALU, accumulator and register file sit outside this block.

Parameters:
PC_W, 8, program counter / instruction address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= PC)
imem_rdata  in  8  fetched byte, valid only in the imem_ack cycle
imem_ack  in  1  fetch complete
alu_sel  out  4  ALU opcode
alu_z  in  1  ALU zero output
alu_c  in  1  ALU carry output
rf_addr  out  4  register index (IR[3:0])
rf_we  out  1  register-file write strobe (writes accumulator to rf_addr)
acc_we  out  1  accumulator load strobe
acc_src  out  2  accumulator source: 0 = ALU result, 1 = RF data, 2 = imm
imm  out  8  operand byte for LDI
flag_z  out  1  latched zero flag
flag_c  out  1  latched carry flag
halted  out  1  high in HALT state
illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Reset (rst=1 at posedge): PC=RESET_PC, IR=0, imm=0, flag_z=0, flag_c=0, state=FETCH. While rst is high: all strobes (imem_req, acc_we, rf_we, illegal) are forced to 0 and halted=0. Reset overrides any outstanding fetch; an ack arriving during reset is ignored.
- Instruction byte: [7:4] opcode, [3:0] register index. Opcodes:
  - 0000 NOP; 0001 ADD; 0010 SUB; 0011 NOR
  - 0100 MOVR (acc<=R); 0101 MOVA (R<=acc)
  - 0110 JZ; 0111 JC; 1000 JMP; 1001 LDI
  - 1011 SHL; 1100 SHR; 1111 HALT
  - 1010, 1101, 1110 are illegal.
- JZ, JC, JMP and LDI are two-byte instructions. The second byte is the target address or immediate.
- States: FETCH, DECODE, FETCH2, EXEC, HALT.
- FETCH:
  - imem_req=1 and imem_addr=PC, both held stable until imem_ack.
  - On ack: IR<=imem_rdata, PC<=PC+1, go to DECODE.
  - With no ack, remain in FETCH; wait states are unbounded.
- DECODE:
  - Two-byte opcode → FETCH2.
  - HALT → HALT.
  - Illegal opcode: illegal=1 for this cycle, then → FETCH (executes as NOP).
  - NOP → FETCH.
  - Otherwise → EXEC.
- FETCH2:
  - Same handshake as FETCH. On ack: imm<=imem_rdata, PC<=PC+1, → EXEC.
- EXEC (exactly one cycle, then → FETCH):
  - ADD/SUB/NOR/SHL/SHR: alu_sel=opcode, acc_src=0, acc_we=1. flag_z<=alu_z. flag_c<=alu_c, except NOR, which leaves flag_c unchanged.
  - MOVR: acc_src=1, acc_we=1. Flags unchanged.
  - MOVA: rf_we=1. Flags unchanged.
  - LDI: acc_src=2, acc_we=1. Flags unchanged.
  - JMP: PC<=imm.
  - JZ: PC<=imm if flag_z, else PC unchanged (already past the operand).
  - JC: same as JZ using flag_c.
- alu_sel=0000 in every state other than EXEC of an ALU op. acc_we and rf_we are high only in EXEC.
- Latency with zero-wait memory:
  - ALU, MOV and NOP ops: 3 cycles (NOP: 2).
  - Two-byte ops: 4 cycles.
- Flags sampled by JZ/JC are those latched by the most recent ALU op, never the live alu_z/alu_c.
- PC wraps modulo 2^PC_W (0xFF+1 → 0x00), including an operand fetch at 0xFF.
- HALT: halted=1 and no requests issued. The block stays in HALT until rst.
- imem_ack while imem_req=0 is ignored.

Decomposition:
- Package cpu_pkg:
  - opcode localparams (values above, shared with the ALU)
  - state enum
  - acc_src encodings
  - is_two_byte helper function
- One natural sub-module: cpu_inst_decode. It is combinational, takes the opcode in and produces: alu-op flag, two-byte flag, illegal flag, acc_src, acc_we/rf_we class, branch type.
- The FSM, PC, IR and flags stay in cpu_seq_ctrl.

Test Plan:
- Zero-wait program at 0x00 (LDI 0x80; ADD R1 with RF[1]=0x80; HALT):
  - strobes: acc_we with acc_src=2/imm=0x80, then acc_src=0/alu_sel=0001, with 0x00 and carry returned by the stub ALU
  - flags: flag_z=1, flag_c=1 after ADD
  - end state: halted=1 at cycle 10
  - requests: no further imem_req after the HALT fetch.
- JZ 0x40 with flag_z=1 → next imem_addr=0x40. JZ 0x40 with flag_z=0 at PC=0x10 → next fetch at 0x12. JC behaves the same way with flag_c.
- Three wait cycles on each fetch of LDI 0x5A:
  - imem_addr is stable while imem_req is high
  - acc_we fires exactly once, with imm=0x5A
  - PC advances by 2 in total.
- NOR following an ADD that set carry: flag_c stays 1 and flag_z tracks alu_z.
- Opcode 1101 → illegal pulses for one cycle, no acc_we/rf_we, next fetch at PC+1. Two-byte op at 0xFF → operand fetched at 0x00, next fetch at 0x01.
- rst asserted while FETCH is waiting (no ack):
  - next cycle: imem_req=0, PC=RESET_PC, flags 0
  - the late ack is ignored
  - fetch restarts at RESET_PC after rst drops.
